// File: rtl/pkt_buf_pkg.sv
// Shared types and helpers for the Avalon-ST store-and-forward packet buffer.
package pkt_buf_pkg;

  // IDLE: between packets | WRITE: storing a packet | DROP: discarding rest of a packet
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DROP  = 2'd2
  } wr_state_t;

  // Pointers carry one extra wrap bit so a full buffer differs from an empty one.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no array reset.
module sdp_ram
  import pkt_buf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/avalon_st_pkt_buffer.sv
// Store-and-forward packet buffer: packets become visible downstream only once
// their EOP is stored; packets that do not fit are dropped whole.
module avalon_st_pkt_buffer
  import pkt_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int DEPTH = 64,
  parameter int CNT_WIDTH = 32,
  localparam int EMPTY_WIDTH = $clog2(DATA_WIDTH/8),
  localparam int LVL_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  i_data_in,
  input  logic                   i_valid_in,
  input  logic                   i_sop_in,
  input  logic                   i_eop_in,
  input  logic [EMPTY_WIDTH-1:0] i_empty_in,
  output logic                   o_ready_out,
  output logic [DATA_WIDTH-1:0]  o_data_out,
  output logic                   o_valid_out,
  output logic                   o_sop_out,
  output logic                   o_eop_out,
  output logic [EMPTY_WIDTH-1:0] o_empty_out,
  input  logic                   i_ready_in,
  output logic [CNT_WIDTH-1:0]   o_pkt_cnt,
  output logic [CNT_WIDTH-1:0]   o_drop_cnt,
  output logic [CNT_WIDTH-1:0]   o_err_cnt,
  output logic [LVL_WIDTH-1:0]   o_level
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] PTR_FULL = PW'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic                   sop;
    logic                   eop;
    logic [EMPTY_WIDTH-1:0] empty;
  } pkt_entry_t;

  localparam int ENTRY_W = $bits(pkt_entry_t);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic en);
    return (en && (v != '1)) ? v + CNT_ONE : v;
  endfunction

  wr_state_t state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_q, commit_d;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] used_wr, used_cm;
  logic [CNT_WIDTH-1:0] pkt_cnt_q, drop_cnt_q, err_cnt_q;
  logic pkt_inc, drop_inc, err_inc, start_pkt;
  logic ram_we;
  logic [AW-1:0] ram_waddr;
  pkt_entry_t ram_wdata, ram_rdata, out_q;
  logic s1_valid_q, out_valid_q, s1_adv, pop;

  assign used_wr = wr_ptr_q - rd_ptr_q;
  assign used_cm = commit_q - rd_ptr_q;
  assign ram_wdata = '{data: i_data_in, sop: i_sop_in, eop: i_eop_in, empty: i_empty_in};

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    commit_d  = commit_q;
    ram_we    = 1'b0;
    ram_waddr = wr_ptr_q[AW-1:0];
    pkt_inc   = 1'b0;
    drop_inc  = 1'b0;
    err_inc   = 1'b0;
    start_pkt = 1'b0;
    if (i_valid_in) begin
      case (state_q)
        IDLE: begin
          if (i_sop_in) start_pkt = 1'b1;
          else          err_inc = 1'b1;
        end
        WRITE: begin
          if (i_sop_in) begin
            err_inc   = 1'b1;
            start_pkt = 1'b1;
          end else if (used_wr == PTR_FULL) begin
            wr_ptr_d = commit_q;
            drop_inc = 1'b1;
            state_d  = i_eop_in ? IDLE : DROP;
          end else begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (i_eop_in) begin
              commit_d = wr_ptr_q + PTR_ONE;
              pkt_inc  = 1'b1;
              state_d  = IDLE;
            end
          end
        end
        DROP: begin
          if (i_sop_in)      start_pkt = 1'b1;
          else if (i_eop_in) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      // Every new packet lands at commit_ptr, which also discards an unterminated one.
      if (start_pkt) begin
        wr_ptr_d = commit_q;
        if (used_cm == PTR_FULL) begin
          drop_inc = 1'b1;
          state_d  = i_eop_in ? IDLE : DROP;
        end else begin
          ram_we    = 1'b1;
          ram_waddr = commit_q[AW-1:0];
          wr_ptr_d  = commit_q + PTR_ONE;
          if (i_eop_in) begin
            commit_d = commit_q + PTR_ONE;
            pkt_inc  = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = WRITE;
          end
        end
      end
    end
  end

  // Two-stage read pipe (RAM data register, then output register) that never bubbles.
  assign s1_adv = s1_valid_q && (!out_valid_q || i_ready_in);
  assign pop    = (rd_ptr_q != commit_q) && (!s1_valid_q || s1_adv);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      commit_q    <= '0;
      rd_ptr_q    <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      pkt_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      commit_q   <= commit_d;
      pkt_cnt_q  <= sat_inc(pkt_cnt_q, pkt_inc);
      drop_cnt_q <= sat_inc(drop_cnt_q, drop_inc);
      err_cnt_q  <= sat_inc(err_cnt_q, err_inc);
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (pop)         s1_valid_q <= 1'b1;
      else if (s1_adv) s1_valid_q <= 1'b0;
      if (s1_adv) begin
        out_q       <= ram_rdata;
        out_valid_q <= 1'b1;
      end else if (i_ready_in) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  sdp_ram #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (pop),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  assign o_ready_out = !reset;
  assign o_data_out  = out_q.data;
  assign o_sop_out   = out_q.sop;
  assign o_eop_out   = out_q.eop;
  assign o_empty_out = out_q.empty;
  assign o_valid_out = out_valid_q;
  assign o_pkt_cnt   = pkt_cnt_q;
  assign o_drop_cnt  = drop_cnt_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_level     = used_cm;

endmodule

// File: tb/tb_avalon_st_pkt_buffer.sv
// Bench for avalon_st_pkt_buffer: directed scenarios plus random traffic checked
// against a packet-level queue model of what must come out.
module tb_avalon_st_pkt_buffer;

  localparam int DW = 512;
  localparam int DEPTH = 64;
  localparam int CW = 32;
  localparam int EW = 6;
  localparam int LW = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] i_data_in;
  logic          i_valid_in, i_sop_in, i_eop_in;
  logic [EW-1:0] i_empty_in;
  logic          o_ready_out;
  logic [DW-1:0] o_data_out;
  logic          o_valid_out, o_sop_out, o_eop_out;
  logic [EW-1:0] o_empty_out;
  logic          i_ready_in;
  logic [CW-1:0] o_pkt_cnt, o_drop_cnt, o_err_cnt;
  logic [LW-1:0] o_level;

  always #5 clk = ~clk;

  avalon_st_pkt_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .i_data_in(i_data_in), .i_valid_in(i_valid_in), .i_sop_in(i_sop_in),
    .i_eop_in(i_eop_in), .i_empty_in(i_empty_in), .o_ready_out(o_ready_out),
    .o_data_out(o_data_out), .o_valid_out(o_valid_out), .o_sop_out(o_sop_out),
    .o_eop_out(o_eop_out), .o_empty_out(o_empty_out), .i_ready_in(i_ready_in),
    .o_pkt_cnt(o_pkt_cnt), .o_drop_cnt(o_drop_cnt), .o_err_cnt(o_err_cnt),
    .o_level(o_level)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } beat_t;

  beat_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int first_valid_cyc = -1;
  int last_eop_cyc = 0;
  int exp_pkt = 0, exp_drop = 0, exp_err = 0;
  bit rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (!reset && o_valid_out) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (i_ready_in) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {{(DW-1){1'b0}}, o_valid_out}, '0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", o_data_out, e.data);
          chk("out_sop", {{(DW-1){1'b0}}, o_sop_out}, {{(DW-1){1'b0}}, e.sop});
          chk("out_eop", {{(DW-1){1'b0}}, o_eop_out}, {{(DW-1){1'b0}}, e.eop});
          chk("out_empty", {{(DW-EW){1'b0}}, o_empty_out}, {{(DW-EW){1'b0}}, e.empty});
        end
      end
    end
  end

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic drive(input logic sop, input logic eop, input logic [EW-1:0] emp,
                       input logic [DW-1:0] d);
    i_valid_in = 1'b1;
    i_sop_in   = sop;
    i_eop_in   = eop;
    i_empty_in = emp;
    i_data_in  = d;
    if (rand_rdy) i_ready_in = ($urandom_range(0, 3) != 0);
    @(posedge clk); #1;
    i_valid_in = 1'b0;
    i_sop_in   = 1'b0;
    i_eop_in   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      if (rand_rdy) i_ready_in = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
  endtask

  // Sends one packet; beats are queued as expected output only if the model says it commits.
  task automatic send_pkt(input int len, input bit commits, input bit no_eop);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data  = rand_data();
      b.sop   = (i == 0);
      b.eop   = (i == len - 1) && !no_eop;
      b.empty = b.eop ? EW'($urandom_range(0, 63)) : '0;
      if (commits) exp_q.push_back(b);
      if (b.eop) last_eop_cyc = cyc + 1;
      drive(b.sop, b.eop, b.empty, b.data);
    end
  endtask

  task automatic drain(input string tag);
    int k;
    rand_rdy = 1'b0;
    i_ready_in = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_drain_left"}, exp_q.size(), 0);
    idle(4);
    chk({tag, "_valid_after"}, {{(DW-1){1'b0}}, o_valid_out}, '0);
    chk({tag, "_level_after"}, {{(DW-LW){1'b0}}, o_level}, '0);
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_pkt_cnt"}, o_pkt_cnt, exp_pkt);
    chk({tag, "_drop_cnt"}, o_drop_cnt, exp_drop);
    chk({tag, "_err_cnt"}, o_err_cnt, exp_err);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int len, r;
    int k;
    bit open;

    reset = 1'b1;
    i_data_in = '0; i_valid_in = 1'b0; i_sop_in = 1'b0; i_eop_in = 1'b0;
    i_empty_in = '0; i_ready_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {{(DW-1){1'b0}}, o_valid_out}, '0);
    chk("rst_ready", {{(DW-1){1'b0}}, o_ready_out}, '0);
    chk("rst_data", o_data_out, '0);
    chk("rst_level", {{(DW-LW){1'b0}}, o_level}, '0);
    chk_cnts("rst");
    reset = 1'b0;
    #1;
    chk("ready_after_rst", {{(DW-1){1'b0}}, o_ready_out}, 1);

    // 1: three back-to-back 4-beat packets, first output 2 cycles after first EOP edge
    i_ready_in = 1'b1;
    send_pkt(4, 1, 0);
    k = last_eop_cyc;
    send_pkt(4, 1, 0);
    send_pkt(4, 1, 0);
    exp_pkt += 3;
    drain("t1");
    chk("t1_latency", first_valid_cyc, k + 2);
    chk_cnts("t1");

    // 2: 60-beat packet held, 10-beat packet cannot fit
    i_ready_in = 1'b0;
    send_pkt(60, 1, 0);
    exp_pkt++;
    chk("t2_level_60", {{(DW-LW){1'b0}}, o_level}, 60);
    send_pkt(10, 0, 0);
    exp_drop++;
    idle(4);
    chk("t2_head_held", {{(DW-1){1'b0}}, o_valid_out}, 1);
    chk_cnts("t2");
    drain("t2");

    // 3: packet longer than the buffer is dropped, the next one passes
    i_ready_in = 1'b1;
    send_pkt(70, 0, 0);
    exp_drop++;
    send_pkt(2, 1, 0);
    exp_pkt++;
    drain("t3");
    chk_cnts("t3");

    // 4: missing EOP, then a single-beat packet
    send_pkt(3, 0, 1);
    send_pkt(1, 1, 0);
    exp_err++;
    exp_pkt++;
    drain("t4");
    chk_cnts("t4");

    // 5: stray body beats outside a packet
    drive(1'b0, 1'b0, '0, rand_data());
    drive(1'b0, 1'b1, 6'd3, rand_data());
    exp_err += 2;
    idle(4);
    chk("t5_no_output", {{(DW-1){1'b0}}, o_valid_out}, '0);
    chk_cnts("t5");
    send_pkt(2, 1, 0);
    exp_pkt++;
    drain("t5");

    // random traffic with random downstream readiness
    rand_rdy = 1'b1;
    open = 1'b0;
    for (int p = 0; p < 60; p++) begin
      r = $urandom_range(0, 9);
      len = $urandom_range(1, 8);
      k = 0;
      while (exp_q.size() + len > 32 && k < 500) begin
        idle(1);
        k++;
      end
      if (r == 0 && !open) begin
        drive(1'b0, $urandom_range(0, 1) != 0, '0, rand_data());
        exp_err++;
      end else begin
        if (open) exp_err++;
        if (r == 1) begin
          send_pkt(len, 0, 1);
          open = 1'b1;
        end else begin
          send_pkt(len, 1, 0);
          exp_pkt++;
          open = 1'b0;
        end
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    if (open) exp_err++;
    send_pkt(3, 1, 0);
    exp_pkt++;
    drain("rnd");
    chk_cnts("rnd");

    // 6: reset in mid-packet with two packets committed
    i_ready_in = 1'b0;
    send_pkt(2, 1, 0);
    send_pkt(3, 1, 0);
    drive(1'b1, 1'b0, '0, rand_data());
    drive(1'b0, 1'b0, '0, rand_data());
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    exp_pkt = 0; exp_drop = 0; exp_err = 0;
    chk("t6_valid", {{(DW-1){1'b0}}, o_valid_out}, '0);
    chk("t6_data", o_data_out, '0);
    chk("t6_sop_eop", {{(DW-2){1'b0}}, o_sop_out, o_eop_out}, '0);
    chk("t6_empty", {{(DW-EW){1'b0}}, o_empty_out}, '0);
    chk("t6_level", {{(DW-LW){1'b0}}, o_level}, '0);
    chk("t6_ready", {{(DW-1){1'b0}}, o_ready_out}, '0);
    chk_cnts("t6_rst");
    @(posedge clk); #1;
    reset = 1'b0;
    i_ready_in = 1'b1;
    idle(2);
    send_pkt(1, 1, 0);
    exp_pkt++;
    drain("t6");
    chk_cnts("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/avalon_st_pkt_buffer.md
Name: avalon_st_pkt_buffer

Overview:
Store-and-forward packet buffer between the pcapreader512 Avalon-ST source and txr_to_noc_basic, one instance per source.
- Absorbs bursts so the source is never backpressured.
- Releases a packet downstream only after its EOP is stored.
- Drops whole packets that do not fit, and discards malformed framing.
- Exposes packet, drop and error counters for the monitor.

Parameters:
DATA_WIDTH, 512, beat width in bits; multiple of 64.
DEPTH, 64, buffer depth in beats; power of 2, at least 4.
CNT_WIDTH, 32, width of statistics counters.
EMPTY_WIDTH, $clog2(DATA_WIDTH/8), width of the empty field (localparam).

Ports:
clk  in  1  clock (one clock domain).
reset  in  1  synchronous, active-high reset.
i_data_in  in  DATA_WIDTH  input beat data.
i_valid_in  in  1  input beat valid.
i_sop_in  in  1  input start of packet.
i_eop_in  in  1  input end of packet.
i_empty_in  in  EMPTY_WIDTH  unused bytes in the EOP beat.
o_ready_out  out  1  ready to upstream.
o_data_out  out  DATA_WIDTH  output beat data.
o_valid_out  out  1  output beat valid.
o_sop_out  out  1  output start of packet.
o_eop_out  out  1  output end of packet.
o_empty_out  out  EMPTY_WIDTH  output empty field.
i_ready_in  in  1  downstream ready.
o_pkt_cnt  out  CNT_WIDTH  packets committed.
o_drop_cnt  out  CNT_WIDTH  packets dropped for lack of space.
o_err_cnt  out  CNT_WIDTH  framing errors.
o_level  out  $clog2(DEPTH)+1  committed beats not yet read.

Behaviour:
Reset values:
- All outputs are 0.
- Pointers (wr_ptr, commit_ptr, rd_ptr) are 0; each has a wrap bit, width $clog2(DEPTH)+1.
- Write FSM is IDLE.

Input side:
- o_ready_out = !reset. Input is never backpressured.
- A beat is accepted on any edge where i_valid_in=1.
- Free space is DEPTH - (wr_ptr - rd_ptr), modulo 2^($clog2(DEPTH)+1).
- Each stored entry holds {data, sop, eop, empty}.

Write FSM (IDLE, WRITE, DROP):
- IDLE, beat with sop=1, space available: write at wr_ptr, wr_ptr++.
  - If eop=1 as well: commit immediately and stay in IDLE.
  - Otherwise go to WRITE.
- IDLE, beat with sop=1, buffer full: drop_cnt++; go to DROP, or stay in IDLE if eop=1.
- IDLE, beat with sop=0: err_cnt++, discard the beat, stay in IDLE.
- WRITE, beat with sop=1 (missing EOP):
  - err_cnt++ and rewind wr_ptr to commit_ptr.
  - In the same cycle, handle the beat as an IDLE SOP, writing at commit_ptr.
- WRITE, buffer full: rewind wr_ptr to commit_ptr, drop_cnt++; go to DROP, or IDLE if eop=1.
- WRITE, otherwise: write the beat. On eop=1, commit_ptr <= wr_ptr+1, pkt_cnt++, go to IDLE.
- DROP: discard beats until eop=1, then go to IDLE. A beat with sop=1 in DROP is handled as in IDLE.
- A packet longer than DEPTH beats is always dropped.

Read side:
- Committed data exists when rd_ptr != commit_ptr.
- RAM read is registered and feeds a one-entry show-ahead output register.
- o_valid_out holds until i_ready_in=1. The output register and RAM read must sustain 1 beat/cycle back-to-back.
- Latency: when the output stage is empty, the first beat appears on o_valid_out exactly 2 cycles after the edge that committed its EOP.
- Commit and read may occur in the same cycle. Reads never pass commit_ptr.
- o_level = commit_ptr - rd_ptr, counted at pop from the RAM (excludes the output register).

Other rules:
- Counters saturate at all-ones.
- Reset in mid-packet discards all contents. No partial packet is ever emitted.
- Output framing is always sop ... eop, with no interleaving.

Decomposition:
Package pkt_buf_pkg holds:
- wr_state_t enum {IDLE, WRITE, DROP};
- the pkt_entry_t struct {data, sop, eop, empty}, parameterised via DATA_WIDTH in the module or a typedef in the module;
- a pointer-width function.

One sub-module, sdp_ram: simple dual-port, registered read, DEPTH x entry width, no reset on the array.

Test Plan:
1. Three 4-beat packets back-to-back, i_ready_in=1 → identical beats out in order; first output sop exactly 2 cycles after the first eop is accepted; o_pkt_cnt=3.
2. DEPTH=64: a 60-beat packet, then a 10-beat packet with i_ready_in=0 → second packet dropped; o_drop_cnt=1; after raising ready only the 60-beat packet is emitted; o_level reaches 60 then 0.
3. 70-beat packet → dropped, o_drop_cnt=1, nothing emitted; a following 2-beat packet passes through.
4. sop, 2 body beats, then sop+eop single beat → o_err_cnt=1; only the 1-beat packet is emitted.
5. Body beat with no preceding sop in IDLE → o_err_cnt=1, no output, FSM stays in IDLE.
6. Reset asserted in mid-packet with 2 packets committed → all outputs 0 next cycle, o_valid_out=0; after release, a new 1-beat packet emerges unaltered.
